// File: rtl/alu_iter.sv
// alu_iter: multi-cycle ALU, short ops in fixed latency, MUL/DIV/REM by WIDTH-step iteration
module alu_iter #(
  parameter int WIDTH = 8,
  parameter int CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryin,
  input  logic             oe,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_dz
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ITER, S_FIXUP, S_DONE} state_t;
  state_t             r_state;
  logic [3:0]         r_op;
  logic               r_sgn, r_cin, r_neg_q, r_neg_r, r_done;
  logic [WIDTH-1:0]   r_a, r_b, r_ma, r_mb, r_result, r_rem;
  logic [2*WIDTH-1:0] r_p;
  logic [CW-1:0]      r_cnt;
  logic               r_z, r_n, r_c, r_v, r_dz;
  logic               w_iter, w_mul, w_ci, w_addv, w_bz, w_mulv, w_divv;
  logic [WIDTH-1:0]   w_bx, w_ma, w_mb, w_q, w_r;
  logic [WIDTH:0]     w_sum, w_hi, w_sh, w_diff;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_res, w_rm;
  logic               w_c, w_v, w_dz, w_zn_en;
  assign w_iter = r_op[3:2] == 2'b10;
  assign w_mul  = r_op[3:1] == 3'b100;
  // SUB/SBC use ~b; SUB forces carry-in 1, ADC/SBC take the latched carry
  assign w_bx   = r_op[0] ? ~r_b : r_b;
  assign w_ci   = r_op[1] ? r_cin : r_op[0];
  assign w_sum  = {1'b0, r_a} + {1'b0, w_bx} + {{WIDTH{1'b0}}, w_ci};
  assign w_addv = (r_a[WIDTH-1] == w_bx[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
  assign w_ma   = (r_sgn && r_a[WIDTH-1]) ? -r_a : r_a;
  assign w_mb   = (r_sgn && r_b[WIDTH-1]) ? -r_b : r_b;
  assign w_bz   = r_b == '0;
  // r_p holds {acc, multiplier} for MUL and {partial remainder, dividend/quotient} for DIV
  assign w_hi   = {1'b0, r_p[2*WIDTH-1:WIDTH]} + {1'b0, r_p[0] ? r_ma : {WIDTH{1'b0}}};
  assign w_sh   = {r_p[2*WIDTH-1:WIDTH], r_p[WIDTH-1]};
  assign w_diff = w_sh - {1'b0, r_mb};
  assign w_prod = r_neg_q ? -r_p : r_p;
  assign w_q    = w_bz ? '1 : r_neg_q ? -r_p[WIDTH-1:0] : r_p[WIDTH-1:0];
  assign w_r    = w_bz ? r_a : r_neg_r ? -r_p[2*WIDTH-1:WIDTH] : r_p[2*WIDTH-1:WIDTH];
  assign w_mulv = r_sgn ? (w_prod[2*WIDTH-1:WIDTH] != {WIDTH{w_prod[WIDTH-1]}})
                        : (w_prod[2*WIDTH-1:WIDTH] != '0);
  assign w_divv = r_sgn && (r_op == 4'd10) && (r_a == {1'b1, {(WIDTH-1){1'b0}}}) && (r_b == '1);
  // next result and flags: short ops evaluated in LOAD, iterative ops in FIXUP
  always_comb begin
    w_res   = '0;
    w_rm    = '0;
    w_c     = 1'b0;
    w_v     = 1'b0;
    w_dz    = 1'b0;
    w_zn_en = 1'b1;
    if (r_state == S_FIXUP) begin
      w_res = (r_op == 4'd8) ? w_prod[WIDTH-1:0] : (r_op == 4'd9) ? w_prod[2*WIDTH-1:WIDTH] :
              (r_op == 4'd10) ? w_q : w_r;
      w_rm  = w_mul ? '0 : w_r;
      w_v   = w_mul ? w_mulv : w_divv;
      w_dz  = !w_mul && w_bz;
    end else begin
      w_res   = (r_op[3:2] == 2'b00) ? w_sum[WIDTH-1:0] : (r_op == 4'd4) ? (r_a & r_b) :
                (r_op == 4'd5) ? (r_a | r_b) : (r_op == 4'd6) ? (r_a ^ r_b) :
                (r_op == 4'd7) ? ~r_a : '0;
      w_c     = (r_op[3:2] == 2'b00) && w_sum[WIDTH];
      w_v     = (r_op[3:2] == 2'b00) && w_addv;
      w_zn_en = !r_op[3];
    end
  end
  // control FSM with datapath registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_done   <= 1'b0;
      r_result <= '0;
      r_rem    <= '0;
      r_z      <= 1'b0;
      r_n      <= 1'b0;
      r_c      <= 1'b0;
      r_v      <= 1'b0;
      r_dz     <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_done <= 1'b0;
      if ((r_state == S_LOAD && !w_iter) || r_state == S_FIXUP) begin
        r_result <= w_res;
        r_rem    <= w_rm;
        r_z      <= w_zn_en && (w_res == '0);
        r_n      <= w_zn_en && w_res[WIDTH-1];
        r_c      <= w_c;
        r_v      <= w_v;
        r_dz     <= w_dz;
      end
      case (r_state)
        S_IDLE: if (start) begin
          r_op    <= op;
          r_sgn   <= signed_mode;
          r_a     <= a;
          r_b     <= b;
          r_cin   <= carryin;
          r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_ma    <= w_ma;
          r_mb    <= w_mb;
          r_neg_q <= r_sgn && (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
          r_neg_r <= r_sgn && r_a[WIDTH-1];
          r_p     <= {{WIDTH{1'b0}}, w_mul ? w_mb : w_ma};
          r_cnt   <= CW'(WIDTH);
          r_state <= w_iter ? S_ITER : S_DONE;
        end
        S_ITER: begin
          r_p     <= w_mul ? {w_hi, r_p[WIDTH-1:1]}
                           : {w_diff[WIDTH] ? w_sh[WIDTH-1:0] : w_diff[WIDTH-1:0], r_p[WIDTH-2:0], ~w_diff[WIDTH]};
          r_cnt   <= r_cnt - CW'(1);
          r_state <= (r_cnt == CW'(1)) ? S_FIXUP : S_ITER;
        end
        S_FIXUP: r_state <= S_DONE;
        S_DONE: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign busy      = r_state != S_IDLE;
  assign done      = r_done;
  assign result    = oe ? r_result : '0;
  assign remainder = r_rem;
  assign flag_z    = r_z;
  assign flag_n    = r_n;
  assign flag_c    = r_c;
  assign flag_v    = r_v;
  assign flag_dz   = r_dz;
endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: scoreboard bench for alu_iter against an arithmetic reference model
module tb_alu_iter;
  localparam int W = 8;
  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] rem;
    logic z, n, c, v, dz, oe;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, signed_mode = 1'b0, carryin = 1'b0, oe = 1'b1;
  logic [3:0] op = '0;
  logic [W-1:0] a = '0, b = '0;
  logic busy, done, flag_z, flag_n, flag_c, flag_v, flag_dz;
  logic [W-1:0] result, remainder;
  int n_checks = 0, n_fail = 0, n_done = 0, n_issued = 0;
  exp_t sb_q[$];
  exp_t m_e;
  alu_iter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .signed_mode(signed_mode),
    .a(a), .b(b), .carryin(carryin), .oe(oe), .busy(busy), .done(done),
    .result(result), .remainder(remainder), .flag_z(flag_z), .flag_n(flag_n),
    .flag_c(flag_c), .flag_v(flag_v), .flag_dz(flag_dz)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic exp_t model(input logic [3:0] o, input logic sg, input logic [W-1:0] x,
                                 input logic [W-1:0] y, input logic ci, input logic oe_v);
    exp_t e;
    int ux, uy, sx, sy, ix, iy, s, ss, p, q, r;
    ux = int'(x);
    uy = int'(y);
    sx = x[W-1] ? ux - 256 : ux;
    sy = y[W-1] ? uy - 256 : uy;
    ix = sg ? sx : ux;
    iy = sg ? sy : uy;
    e = '{res: '0, rem: '0, z: 0, n: 0, c: 0, v: 0, dz: 0, oe: oe_v};
    s = 0;
    ss = 0;
    case (o)
      4'd0: begin s = ux + uy; ss = sx + sy; end
      4'd1: begin s = ux + (255 - uy) + 1; ss = sx - sy; end
      4'd2: begin s = ux + uy + int'(ci); ss = sx + sy + int'(ci); end
      4'd3: begin s = ux + (255 - uy) + int'(ci); ss = sx - sy - 1 + int'(ci); end
      4'd4: e.res = x & y;
      4'd5: e.res = x | y;
      4'd6: e.res = x ^ y;
      4'd7: e.res = ~x;
      4'd8, 4'd9: begin
        p = ix * iy;
        e.res = (o == 4'd8) ? p[7:0] : p[15:8];
        e.v = sg ? (p < -128 || p > 127) : (p > 255);
      end
      4'd10, 4'd11: begin
        if (uy == 0) begin
          q = 255;
          r = ux;
          e.dz = 1'b1;
        end else begin
          q = ix / iy;
          r = ix % iy;
          e.v = (o == 4'd10) && sg && ix == -128 && iy == -1;
        end
        e.res = (o == 4'd10) ? q[7:0] : r[7:0];
        e.rem = r[7:0];
      end
      default: ;
    endcase
    if (o < 4'd4) begin
      e.res = s[7:0];
      e.c = s[8];
      e.v = ss > 127 || ss < -128;
    end
    e.z = (o < 4'd12) && (e.res == '0);
    e.n = (o < 4'd12) && e.res[W-1];
    return e;
  endfunction
  task automatic run_op(input logic [3:0] o, input logic sg, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci, input logic oe_v, input int poke);
    exp_t e;
    int lat, k;
    bit got;
    e = model(o, sg, x, y, ci, oe_v);
    lat = (o >= 4'd8 && o <= 4'd11) ? W + 3 : 2;
    @(negedge clk);
    op = o; signed_mode = sg; a = x; b = y; carryin = ci; oe = oe_v; start = 1'b1;
    sb_q.push_back(e);
    n_issued++;
    @(posedge clk);
    #1 start = 1'b0;
    got = 0;
    k = 0;
    while (!got && k < 40) begin
      k++;
      if (k == poke) begin
        @(negedge clk);
        start = 1'b1;
        op = 4'($urandom_range(0, 15));
        a = W'($urandom);
        b = W'($urandom);
      end
      @(posedge clk);
      #1 start = 1'b0;
      if (done) got = 1;
      else chk("busy_during_op", busy, 1);
    end
    chk("done_latency", got ? k : 99, lat);
    chk("busy_at_done", busy, 0);
    @(posedge clk);
    #1;
    chk("busy_after_done", busy, 0);
    chk("done_one_cycle", done, 0);
    chk("result_hold", result, oe_v ? e.res : '0);
  endtask
  // scoreboard monitor: compares every done pulse against the oldest expectation
  always @(posedge clk) begin
    #2;
    if (!rst && done) begin
      n_done++;
      if (sb_q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        m_e = sb_q.pop_front();
        chk("result", result, m_e.oe ? m_e.res : '0);
        chk("remainder", remainder, m_e.rem);
        chk("flag_z", flag_z, m_e.z);
        chk("flag_n", flag_n, m_e.n);
        chk("flag_c", flag_c, m_e.c);
        chk("flag_v", flag_v, m_e.v);
        chk("flag_dz", flag_dz, m_e.dz);
      end
    end
  end
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_result", result, 0);
    chk("reset_remainder", remainder, 0);
    chk("reset_flags", {flag_z, flag_n, flag_c, flag_v, flag_dz}, 0);
    rst = 1'b0;
    run_op(4'd0, 0, 8'h7F, 8'h01, 0, 1, 0);
    run_op(4'd1, 0, 8'h10, 8'h20, 0, 1, 0);
    run_op(4'd3, 0, 8'h10, 8'h10, 0, 1, 2);
    run_op(4'd2, 0, 8'hFF, 8'h00, 1, 1, 0);
    run_op(4'd8, 1, 8'hFF, 8'h02, 0, 1, 0);
    run_op(4'd9, 1, 8'hFF, 8'h02, 0, 1, 0);
    run_op(4'd9, 0, 8'hFF, 8'hFF, 0, 1, 3);
    run_op(4'd10, 0, 8'h37, 8'h00, 0, 1, 0);
    run_op(4'd11, 1, 8'h85, 8'h00, 0, 1, 0);
    run_op(4'd10, 1, 8'h80, 8'hFF, 0, 1, 0);
    run_op(4'd11, 1, 8'hF9, 8'h02, 0, 1, 0);
    run_op(4'd13, 0, 8'h12, 8'h34, 0, 1, 0);
    run_op(4'd9, 0, 8'hFF, 8'hFF, 0, 0, 3);
    run_op(4'd8, 0, 8'h0D, 8'h0B, 0, 1, 0);
    // abort a multiply mid-iteration with a one-cycle reset
    @(negedge clk);
    op = 4'd8; signed_mode = 0; a = 8'h0F; b = 8'h0F; oe = 1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_result", result, 0);
    chk("abort_done", done, 0);
    repeat (15) begin
      @(posedge clk);
      #1 chk("abort_idle", {busy, done}, 0);
    end
    run_op(4'd8, 0, 8'h0C, 8'h0B, 0, 1, 0);
    for (int i = 0; i < 80; i++) begin
      logic [W-1:0] ra, rb;
      ra = ($urandom_range(0, 5) == 0) ? 8'h80 : W'($urandom);
      rb = ($urandom_range(0, 6) == 0) ? 8'h00 : ($urandom_range(0, 6) == 0) ? 8'hFF : W'($urandom);
      run_op(4'($urandom_range(0, 15)), 1'($urandom), ra, rb, 1'($urandom), $urandom_range(0, 4) != 0,
             int'($urandom_range(0, 5)));
    end
    repeat (3) @(posedge clk);
    #3;
    chk("scoreboard_empty", sb_q.size(), 0);
    chk("done_count", n_done, n_issued);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
